// File: rtl/ahb_lite_traffic_gen.sv
// AHB-Lite master that writes a seeded pattern to a slave, reads it back and
// reports mismatches, aborts and the first failing address.
module ahb_lite_traffic_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WORDS      = 16,
    parameter int                    BURST_LEN  = 4,
    parameter logic [31:0]           SEED       = 32'hA5A50000
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);
    // state   | meaning
    // IDLE    | waiting for start
    // WRITE   | issuing write address phases
    // WDRAIN  | last write data phase in flight
    // READ    | issuing read address phases
    // RDRAIN  | last read data phase in flight
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_DONE} state_t;

    localparam int                    BYTES_LOG  = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int                    IDX_W      = $clog2(WORDS + 1);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0]      BURST_MASK = IDX_W'(BURST_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] SEED_REP   = {(DATA_WIDTH / 32){SEED}};
    localparam logic [2:0]            HBURST_C   = (BURST_LEN == 8) ? 3'b101 :
                                                   (BURST_LEN == 4) ? 3'b011 : 3'b000;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (ADDR_WIDTH'(idx) << BYTES_LOG);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a);
        return SEED_REP ^ DATA_WIDTH'(a);
    endfunction

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        aidx;
    logic [IDX_W-1:0]        dp_idx;
    logic                    dp_valid;
    logic                    dp_write;
    logic                    err_pend;
    logic [DATA_WIDTH-1:0]   hwdata_q;
    logic                    active;
    logic                    acc;
    logic                    last_acc;
    logic                    resp_abort;
    logic                    rd_mismatch;

    assign HBURST = HBURST_C;
    assign HSIZE  = 3'(BYTES_LOG);
    assign HWDATA = hwdata_q;

    assign acc         = HREADY && HTRANS[1];
    assign last_acc    = acc && (aidx == LAST_IDX);
    assign resp_abort  = busy && dp_valid && HRESP && HREADY;
    assign rd_mismatch = HREADY && !HRESP && dp_valid && !dp_write &&
                         (HRDATA != beat_data(beat_addr(dp_idx)));

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_WRITE;
            S_WRITE:  if (resp_abort) state_nxt = S_DONE;
                      else if (last_acc) state_nxt = S_WDRAIN;
            S_WDRAIN: if (resp_abort) state_nxt = S_DONE;
                      else if (HREADY) state_nxt = S_READ;
            S_READ:   if (resp_abort) state_nxt = S_DONE;
                      else if (last_acc) state_nxt = S_RDRAIN;
            S_RDRAIN: if (resp_abort) state_nxt = S_DONE;
                      else if (HREADY) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        active = 1'b0;
        case (state)
            S_WRITE, S_READ:    begin busy = 1'b1; active = 1'b1; end
            S_WDRAIN, S_RDRAIN: busy = 1'b1;
            S_DONE:             done = 1'b1;
            default:            ;
        endcase
        HSEL   = busy;
        HWRITE = (state == S_WRITE);
        HADDR  = active ? beat_addr(aidx) : '0;
        // A pending error response squashes the transfer being presented.
        if (!active || err_pend)
            HTRANS = 2'b00;
        else if ((aidx & BURST_MASK) == '0)
            HTRANS = 2'b10;
        else
            HTRANS = 2'b11;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            aidx           <= '0;
            dp_idx         <= '0;
            dp_valid       <= 1'b0;
            dp_write       <= 1'b0;
            err_pend       <= 1'b0;
            hwdata_q       <= '0;
            aborted        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                aidx           <= '0;
                aborted        <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end
            // Wrapping to zero after the last write lets the read pass reuse the counter.
            if (acc)
                aidx <= (aidx == LAST_IDX) ? '0 : aidx + 1'b1;
            if (HREADY) begin
                dp_valid <= acc;
                dp_write <= HWRITE;
                dp_idx   <= aidx;
            end
            if (acc && HWRITE)
                hwdata_q <= beat_data(beat_addr(aidx));
            err_pend <= busy && HRESP && !HREADY;
            if (resp_abort)
                aborted <= 1'b1;
            if (rd_mismatch) begin
                if (err_count == '0)
                    first_err_addr <= beat_addr(dp_idx);
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_traffic_gen.sv
// Directed bench for ahb_lite_traffic_gen: three configurations against
// simple memory slaves with wait-state, corruption and error injection.
module tb_ahb_lite_traffic_gen;
    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET;
    logic [2:0]  start_v;
    logic [2:0]  done_v;
    logic        trc_clr;
    int          n_checks;
    int          n_errors;

    logic        ws_en, err_en;
    logic [15:0] corrupt;
    logic [31:0] err_a;

    // instance 0: INCR4, 32-bit
    logic        busy0, done0, aborted0, hsel0, hwrite0, hready0, hresp0;
    logic [15:0] errc0;
    logic [31:0] ferr0, haddr0, hwdata0, hrdata0;
    logic [2:0]  hburst0, hsize0;
    logic [1:0]  htrans0;
    // instance 1: SINGLE, 32-bit, base 0x100
    logic        busy1, done1, aborted1, hsel1, hwrite1, hready1, hresp1;
    logic [15:0] errc1;
    logic [31:0] ferr1, haddr1, hwdata1, hrdata1;
    logic [2:0]  hburst1, hsize1;
    logic [1:0]  htrans1;
    // instance 2: INCR8, 64-bit
    logic        busy2, done2, aborted2, hsel2, hwrite2, hready2, hresp2;
    logic [15:0] errc2;
    logic [31:0] ferr2, haddr2;
    logic [63:0] hwdata2, hrdata2;
    logic [2:0]  hburst2, hsize2;
    logic [1:0]  htrans2;

    assign done_v = {done2, done1, done0};

    ahb_lite_traffic_gen u0 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_v[0]), .busy(busy0), .done(done0),
        .aborted(aborted0), .err_count(errc0), .first_err_addr(ferr0), .HSEL(hsel0),
        .HADDR(haddr0), .HBURST(hburst0), .HSIZE(hsize0), .HTRANS(htrans0), .HWRITE(hwrite0),
        .HWDATA(hwdata0), .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0));

    ahb_lite_traffic_gen #(.BURST_LEN(1), .BASE_ADDR(32'h100)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_v[1]), .busy(busy1), .done(done1),
        .aborted(aborted1), .err_count(errc1), .first_err_addr(ferr1), .HSEL(hsel1),
        .HADDR(haddr1), .HBURST(hburst1), .HSIZE(hsize1), .HTRANS(htrans1), .HWRITE(hwrite1),
        .HWDATA(hwdata1), .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1));

    ahb_lite_traffic_gen #(.DATA_WIDTH(64), .BURST_LEN(8)) u2 (
        .HCLK(HCLK), .HRESET(HRESET), .start(start_v[2]), .busy(busy2), .done(done2),
        .aborted(aborted2), .err_count(errc2), .first_err_addr(ferr2), .HSEL(hsel2),
        .HADDR(haddr2), .HBURST(hburst2), .HSIZE(hsize2), .HTRANS(htrans2), .HWRITE(hwrite2),
        .HWDATA(hwdata2), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2));

    // slave 0: wait states on every 3rd accepted beat, read corruption, write error
    logic [31:0] mem0 [64];
    logic        s_dv, s_dw;
    logic [31:0] s_da;
    logic [1:0]  s_wcnt, s_est;
    int          s_ord;

    assign hready0 = !(s_dv && (s_wcnt != 2'd0 || s_est == 2'd1));
    assign hresp0  = s_dv && (s_est != 2'd0);
    assign hrdata0 = mem0[s_da[7:2]] ^ (corrupt[s_da[5:2]] ? 32'h1 : 32'h0);

    always @(posedge HCLK) begin
        if (HRESET) begin
            s_dv <= 1'b0; s_dw <= 1'b0; s_da <= '0;
            s_wcnt <= '0; s_est <= '0; s_ord <= 0;
        end else begin
            if (hready0) begin
                if (s_dv && s_dw && !hresp0) mem0[s_da[7:2]] <= hwdata0;
                s_dv <= hsel0 && htrans0[1];
                s_dw <= hwrite0;
                s_da <= haddr0;
                if (hsel0 && htrans0[1]) begin
                    s_wcnt <= (ws_en && (s_ord % 3 == 2)) ? 2'd2 : 2'd0;
                    s_est  <= (err_en && hwrite0 && haddr0 == err_a) ? 2'd1 : 2'd0;
                    s_ord  <= s_ord + 1;
                end else begin
                    s_wcnt <= '0;
                    s_est  <= '0;
                end
            end else begin
                if (s_wcnt != 2'd0) s_wcnt <= s_wcnt - 2'd1;
                if (s_est == 2'd1) s_est <= 2'd2;
            end
            if (trc_clr) s_ord <= 0;
        end
    end

    // slaves 1 and 2: zero-wait memories
    logic [31:0] mem1 [64];
    logic [63:0] mem2 [64];
    logic        s1_dv, s1_dw, s2_dv, s2_dw;
    logic [31:0] s1_da, s2_da;
    assign hready1 = 1'b1;
    assign hresp1  = 1'b0;
    assign hrdata1 = mem1[s1_da[7:2]];
    assign hready2 = 1'b1;
    assign hresp2  = 1'b0;
    assign hrdata2 = mem2[s2_da[8:3]];

    always @(posedge HCLK) begin
        if (HRESET) begin
            s1_dv <= 1'b0; s1_dw <= 1'b0; s1_da <= '0;
            s2_dv <= 1'b0; s2_dw <= 1'b0; s2_da <= '0;
        end else begin
            if (s1_dv && s1_dw) mem1[s1_da[7:2]] <= hwdata1;
            s1_dv <= hsel1 && htrans1[1]; s1_dw <= hwrite1; s1_da <= haddr1;
            if (s2_dv && s2_dw) mem2[s2_da[8:3]] <= hwdata2;
            s2_dv <= hsel2 && htrans2[1]; s2_dw <= hwrite2; s2_da <= haddr2;
        end
    end

    // monitors, sampled on the falling edge
    logic [34:0] acc_rec [64];
    logic [31:0] wd0 [16];
    int          n_acc0, n_done0, stall_cnt, stall_bad, hsb_bad;
    int          ns1, sq1, ns2, sq2;
    logic [1:0]  err2_tr, p_tr;
    logic        p_stall, p_wr;
    logic [31:0] p_addr, p_wd;
    logic        cur_stall;
    assign cur_stall = s_dv && !hready0 && !hresp0;

    always @(negedge HCLK) begin
        if (trc_clr) begin
            n_acc0 <= 0; n_done0 <= 0; stall_cnt <= 0; stall_bad <= 0; hsb_bad <= 0;
            err2_tr <= 2'b11; p_stall <= 1'b0;
            ns1 <= 0; sq1 <= 0; ns2 <= 0; sq2 <= 0;
        end else begin
            if (!HRESET && hready0 && htrans0[1]) begin
                if (n_acc0 < 64) acc_rec[n_acc0] <= {hwrite0, htrans0, haddr0};
                n_acc0 <= n_acc0 + 1;
            end
            if (done0) n_done0 <= n_done0 + 1;
            if (hsel0 !== busy0) hsb_bad <= hsb_bad + 1;
            if (hresp0 && hready0) err2_tr <= htrans0;
            if (cur_stall) stall_cnt <= stall_cnt + 1;
            if (p_stall && (haddr0 != p_addr || htrans0 != p_tr || hwdata0 != p_wd || hwrite0 != p_wr))
                stall_bad <= stall_bad + 1;
            p_stall <= cur_stall; p_addr <= haddr0; p_tr <= htrans0; p_wd <= hwdata0; p_wr <= hwrite0;
            if (s_dv && s_dw && hready0 && !hresp0) wd0[s_da[5:2]] <= hwdata0;
            if (htrans1 == 2'b10) ns1 <= ns1 + 1;
            if (htrans1 == 2'b11) sq1 <= sq1 + 1;
            if (htrans2 == 2'b10) ns2 <= ns2 + 1;
            if (htrans2 == 2'b11) sq2 <= sq2 + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int u, output int cyc);
        cyc = 0;
        @(negedge HCLK); trc_clr = 1'b1;
        @(negedge HCLK); trc_clr = 1'b0; start_v[u] = 1'b1;
        @(negedge HCLK); start_v[u] = 1'b0;
        while (!done_v[u] && cyc < 400) begin
            @(negedge HCLK);
            cyc++;
        end
        chk($sformatf("done_seen_u%0d", u), done_v[u], 1'b1);
        @(negedge HCLK);
    endtask

    int          cyc;
    logic [34:0] exp_rec;
    logic        found;
    int          snap;

    initial begin
        n_checks = 0; n_errors = 0;
        HRESET = 1'b1; start_v = '0; trc_clr = 1'b0;
        ws_en = 1'b0; err_en = 1'b0; corrupt = '0; err_a = '0;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);

        chk("rst_ctrl", {htrans0, hsel0, hwrite0, busy0, done0, aborted0}, '0);
        chk("rst_addr", haddr0, 32'h0);
        chk("rst_wdata", hwdata0, 32'h0);
        chk("rst_errs", {errc0, ferr0}, '0);
        chk("hburst0", hburst0, 3'b011);
        chk("hsize0", hsize0, 3'd2);

        // zero-wait run
        run(0, cyc);
        chk("t1_cycles", cyc, 34);
        chk("t1_err_count", errc0, 0);
        chk("t1_first_err", ferr0, 0);
        chk("t1_aborted", aborted0, 0);
        chk("t1_n_acc", n_acc0, 32);
        chk("t1_n_done", n_done0, 1);
        chk("t1_hsel_busy", hsb_bad, 0);
        chk("t1_wdata_04", wd0[1], 32'hA5A50004);
        chk("t1_wdata_3c", wd0[15], 32'hA5A5003C);
        for (int k = 0; k < 32; k++) begin
            exp_rec = {(k < 16) ? 1'b1 : 1'b0, (k % 4 == 0) ? 2'b10 : 2'b11, 32'((k % 16) * 4)};
            chk($sformatf("t1_beat%0d", k), acc_rec[k], exp_rec);
        end

        // two wait states on every 3rd beat: 10 stalled beats over 32
        ws_en = 1'b1;
        run(0, cyc);
        chk("t2_cycles", cyc, 54);
        chk("t2_stall_cycles", stall_cnt, 20);
        chk("t2_stall_stable", stall_bad, 0);
        chk("t2_err_count", errc0, 0);
        chk("t2_n_acc", n_acc0, 32);
        chk("t2_wdata_04", wd0[1], 32'hA5A50004);
        ws_en = 1'b0;

        // read corruption
        corrupt = 16'h0020;
        run(0, cyc);
        chk("t3a_err_count", errc0, 1);
        chk("t3a_first_err", ferr0, 32'h14);
        corrupt = 16'h1220;
        run(0, cyc);
        chk("t3b_err_count", errc0, 3);
        chk("t3b_first_err", ferr0, 32'h14);
        chk("t3b_aborted", aborted0, 0);
        corrupt = '0;

        // error response on write to 0x08
        err_en = 1'b1; err_a = 32'h8;
        run(0, cyc);
        chk("t4_cycles", cyc, 5);
        chk("t4_aborted", aborted0, 1);
        chk("t4_n_acc", n_acc0, 3);
        chk("t4_err2_htrans", err2_tr, 2'b00);
        chk("t4_n_done", n_done0, 1);
        chk("t4_err_count", errc0, 0);
        err_en = 1'b0;

        // SINGLE, base 0x100
        run(1, cyc);
        chk("t5_u1_cycles", cyc, 34);
        chk("t5_u1_nonseq", ns1, 32);
        chk("t5_u1_seq", sq1, 0);
        chk("t5_u1_hburst", hburst1, 3'b000);
        chk("t5_u1_hsize", hsize1, 3'd2);
        chk("t5_u1_err", {aborted1, errc1}, 0);
        chk("t5_u1_mem104", mem1[1], 32'hA5A50104);

        // INCR8, 64-bit
        run(2, cyc);
        chk("t5_u2_cycles", cyc, 34);
        chk("t5_u2_nonseq", ns2, 4);
        chk("t5_u2_seq", sq2, 28);
        chk("t5_u2_hburst", hburst2, 3'b101);
        chk("t5_u2_hsize", hsize2, 3'd3);
        chk("t5_u2_err", {aborted2, errc2}, 0);
        chk("t5_u2_mem08", mem2[1], 64'hA5A50000_A5A50008);

        // reset in the middle of the write pass at beat 6
        @(negedge HCLK); trc_clr = 1'b1;
        @(negedge HCLK); trc_clr = 1'b0; start_v[0] = 1'b1;
        @(negedge HCLK); start_v[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (htrans0 != 2'b00 && hwrite0 && haddr0 == 32'h18) found = 1'b1;
            else @(negedge HCLK);
        end
        chk("t6_beat6_seen", found, 1'b1);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        chk("t6_htrans_idle", htrans0, 2'b00);
        chk("t6_busy_hsel", {busy0, hsel0}, 2'b00);
        chk("t6_aborted", aborted0, 0);
        @(negedge HCLK);
        snap = n_acc0;
        repeat (40) @(negedge HCLK);
        chk("t6_no_more_acc", n_acc0, snap);
        chk("t6_no_done", n_done0, 0);

        run(0, cyc);
        chk("t6_rerun_cycles", cyc, 34);
        chk("t6_rerun_err", {aborted0, errc0}, 0);
        chk("t6_rerun_n_acc", n_acc0, 32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
